db_tupu_wr_ctrl: RTL and testbench

Write/read controller in front of the deblocking TU/PU edge-flag RAM (64 words × 32 bits, single port, active-low CEN/WEN, 1-cycle read latency).
- Accepts one CU descriptor at a time from the mode-decision side and converts it into per-4x4 TU/PU edge flags.
- Merges the flags into the RAM by read-modify-write.
- Serves the downstream boundary-strength stage from the opposite ping-pong bank.

---
 rtl/db_tupu_wr_ctrl_pkg.sv | 43 ++++
 rtl/db_tupu_mask_gen.sv | 66 ++++++
 rtl/db_tupu_wr_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_db_tupu_wr_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_tupu_wr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// db_tupu_wr_ctrl_pkg
// Shared definitions for the deblocking TU/PU edge-flag write controller:
// FSM state encodings, CU partition and size codes, the edge-direction bit
// and a helper that turns a size code into a CU span in 4x4 units.
// ---------------------------------------------------------------------------
package db_tupu_wr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_RD   = 3'd2,
        ST_MOD  = 3'd3,
        ST_WR   = 3'd4
    } state_e;

    // Partition codes
    localparam logic [1:0] PART_2NX2N = 2'd0;
    localparam logic [1:0] PART_2NXN  = 2'd1;
    localparam logic [1:0] PART_NX2N  = 2'd2;
    localparam logic [1:0] PART_NXN   = 2'd3;

    // CU size codes (luma pixels)
    localparam logic [1:0] SIZE_8  = 2'd0;
    localparam logic [1:0] SIZE_16 = 2'd1;
    localparam logic [1:0] SIZE_32 = 2'd2;
    localparam logic [1:0] SIZE_64 = 2'd3;

    // Edge direction, also the dir bit of the RAM address
    localparam logic DIR_VER = 1'b0;
    localparam logic DIR_HOR = 1'b1;

    // CU span in 4x4 blocks: 2 << size
    function automatic logic [4:0] cu_span(input logic [1:0] size);
        case (size)
            SIZE_8:  return 5'd2;
            SIZE_16: return 5'd4;
            SIZE_32: return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/db_tupu_mask_gen.sv
// ---------------------------------------------------------------------------
// db_tupu_mask_gen
// Combinational edge-flag mask for one RAM word of one CU.
// Ports:
//   dir_i        : 0 vertical (left) edges, 1 horizontal (top) edges
//   row_i        : row of the word, in 4x4 units (must lie inside the CU)
//   cu_x_i/y_i   : CU origin in 4x4 units
//   cu_size_i    : size code, cu_part_i : partition code
//   cu_tu_dep_i  : TU split depth
//   mask_o       : bit 2c+1 = TU edge, bit 2c = PU edge, for column c
// ---------------------------------------------------------------------------
module db_tupu_mask_gen
    import db_tupu_wr_ctrl_pkg::*;
(
    input  logic        dir_i,
    input  logic [3:0]  row_i,
    input  logic [3:0]  cu_x_i,
    input  logic [3:0]  cu_y_i,
    input  logic [1:0]  cu_size_i,
    input  logic [1:0]  cu_part_i,
    input  logic [1:0]  cu_tu_dep_i,
    output logic [31:0] mask_o
);

    logic [4:0] span;
    logic [4:0] tu_step;
    logic [4:0] half;
    logic [4:0] row_off;
    logic       hsplit;
    logic       vsplit;
    logic       tu_row;
    logic       pu_row;

    // NOTE: every signal driven here gets a default before any condition,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        mask_o  = '0;
        span    = cu_span(cu_size_i);
        tu_step = span >> cu_tu_dep_i;
        if (tu_step == 5'd0) begin
            tu_step = 5'd1;
        end
        half    = span >> 1;
        row_off = {1'b0, row_i - cu_y_i};
        hsplit  = (cu_part_i == PART_2NXN) || (cu_part_i == PART_NXN);
        vsplit  = (cu_part_i == PART_NX2N) || (cu_part_i == PART_NXN);
        // tu_step is a power of two, so the modulo reduces to a mask.
        tu_row  = (row_off & (tu_step - 5'd1)) == 5'd0;
        pu_row  = (row_off == 5'd0) || (hsplit && (row_off == half));

        for (int c = 0; c < 16; c++) begin
            logic [4:0] k;
            k = 5'(c) - {1'b0, cu_x_i};
            if ((5'(c) >= {1'b0, cu_x_i}) && (k < span)) begin
                if (dir_i == DIR_VER) begin
                    mask_o[2*c+1] = (k & (tu_step - 5'd1)) == 5'd0;
                    mask_o[2*c]   = (k == 5'd0) || (vsplit && (k == half));
                end else begin
                    mask_o[2*c+1] = tu_row;
                    mask_o[2*c]   = pu_row;
                end
            end
        end
    end

endmodule

// File: rtl/db_tupu_wr_ctrl.sv
// ---------------------------------------------------------------------------
// db_tupu_wr_ctrl
// Write/read controller for the deblocking TU/PU edge-flag RAM
// (64 x 32, single port, active-low CEN/WEN, 1-cycle read latency).
// Accepts one CU descriptor at a time, merges its edge flags into the write
// bank by read-modify-write, and serves the boundary-strength reader from
// the other ping-pong bank. The reader always wins the RAM port.
// Ports:
//   lcu_start_i          : swap banks and clear the new write bank
//   cu_vld_i / cu_rdy_o  : descriptor handshake
//   cu_x/y/size/part/tu_dep_i : CU descriptor
//   rd_en_i, rd_dir_i, rd_row_i : reader request (read bank)
//   rd_vld_o, rd_dat_o   : reader response
//   ram_*                : RAM port, address {bank, dir, row}
//   busy_o               : FSM not idle
// ---------------------------------------------------------------------------
module db_tupu_wr_ctrl
    import db_tupu_wr_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcu_start_i,
    input  logic        cu_vld_i,
    output logic        cu_rdy_o,
    input  logic [3:0]  cu_x_i,
    input  logic [3:0]  cu_y_i,
    input  logic [1:0]  cu_size_i,
    input  logic [1:0]  cu_part_i,
    input  logic [1:0]  cu_tu_dep_i,
    input  logic        rd_en_i,
    input  logic        rd_dir_i,
    input  logic [3:0]  rd_row_i,
    output logic [31:0] rd_dat_o,
    output logic        rd_vld_o,
    output logic [5:0]  ram_adr_o,
    output logic        ram_cen_o,
    output logic        ram_wen_o,
    output logic [31:0] ram_wdat_o,
    input  logic [31:0] ram_rdat_i,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic        bank_sel_q, bank_sel_d;
    logic        pend_q, pend_d;
    logic        init_done_q, init_done_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  part_q, part_d;
    logic [1:0]  dep_q, dep_d;
    logic        dir_q, dir_d;
    logic [3:0]  row_q, row_d;
    logic [31:0] word_q, word_d;
    logic [4:0]  clr_cnt_q, clr_cnt_d;
    logic        rd_vld_q;
    logic [31:0] rd_dat_q;

    logic        grant;
    logic        cu_hs;
    logic [4:0]  last_row;
    logic [31:0] mask;

    db_tupu_mask_gen u_mask_gen (
        .dir_i       (dir_q),
        .row_i       (row_q),
        .cu_x_i      (x_q),
        .cu_y_i      (y_q),
        .cu_size_i   (size_q),
        .cu_part_i   (part_q),
        .cu_tu_dep_i (dep_q),
        .mask_o      (mask)
    );

    // The FSM only gets the port in cycles the reader leaves free.
    assign grant    = !rd_en_i;
    assign cu_rdy_o = (state_q == ST_IDLE) && !pend_q && init_done_q;
    assign cu_hs    = cu_vld_i && cu_rdy_o;
    assign busy_o   = (state_q != ST_IDLE);
    assign last_row = {1'b0, y_q} + cu_span(size_q) - 5'd1;
    assign rd_vld_o = rd_vld_q;
    assign rd_dat_o = rd_dat_q;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        bank_sel_d  = bank_sel_q;
        pend_d      = pend_q;
        init_done_d = init_done_q;
        x_d         = x_q;
        y_d         = y_q;
        size_d      = size_q;
        part_d      = part_q;
        dep_d       = dep_q;
        dir_d       = dir_q;
        row_d       = row_q;
        word_d      = word_q;
        clr_cnt_d   = clr_cnt_q;

        // A start that arrives while busy waits for the next IDLE.
        if ((state_q != ST_IDLE) && lcu_start_i) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d    = ST_CLR;
                    bank_sel_d = ~bank_sel_q;
                    pend_d     = 1'b0;
                    clr_cnt_d  = '0;
                end else if (cu_hs) begin
                    // A start coinciding with an accepted CU is deferred
                    // until that CU has been written.
                    state_d = ST_RD;
                    pend_d  = lcu_start_i;
                    x_d     = cu_x_i;
                    y_d     = cu_y_i;
                    size_d  = cu_size_i;
                    part_d  = cu_part_i;
                    dep_d   = cu_tu_dep_i;
                    dir_d   = DIR_VER;
                    row_d   = cu_y_i;
                end else if (lcu_start_i) begin
                    state_d    = ST_CLR;
                    bank_sel_d = ~bank_sel_q;
                    clr_cnt_d  = '0;
                end
            end
            ST_CLR: begin
                if (grant) begin
                    clr_cnt_d = clr_cnt_q + 5'd1;
                    if (clr_cnt_q == 5'd31) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (grant) begin
                    state_d = ST_MOD;
                end
            end
            ST_MOD: begin
                word_d  = ram_rdat_i;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (grant) begin
                    if (row_q == last_row[3:0]) begin
                        if (dir_q == DIR_VER) begin
                            dir_d   = DIR_HOR;
                            row_d   = y_q;
                            state_d = ST_RD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM port: reader first, then whatever the FSM needs this cycle.
    always_comb begin
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_adr_o  = '0;
        ram_wdat_o = '0;
        if (rd_en_i) begin
            ram_cen_o = 1'b0;
            ram_adr_o = {~bank_sel_q, rd_dir_i, rd_row_i};
        end else begin
            case (state_q)
                ST_CLR: begin
                    ram_cen_o = 1'b0;
                    ram_wen_o = 1'b0;
                    ram_adr_o = {bank_sel_q, clr_cnt_q};
                end
                ST_RD: begin
                    ram_cen_o = 1'b0;
                    ram_adr_o = {bank_sel_q, dir_q, row_q};
                end
                ST_WR: begin
                    ram_cen_o  = 1'b0;
                    ram_wen_o  = 1'b0;
                    ram_adr_o  = {bank_sel_q, dir_q, row_q};
                    ram_wdat_o = word_q | mask;
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bank_sel_q  <= 1'b0;
            pend_q      <= 1'b0;
            init_done_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            size_q      <= '0;
            part_q      <= '0;
            dep_q       <= '0;
            dir_q       <= DIR_VER;
            row_q       <= '0;
            word_q      <= '0;
            clr_cnt_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_dat_q    <= '0;
        end else begin
            state_q     <= state_d;
            bank_sel_q  <= bank_sel_d;
            pend_q      <= pend_d;
            init_done_q <= init_done_d;
            x_q         <= x_d;
            y_q         <= y_d;
            size_q      <= size_d;
            part_q      <= part_d;
            dep_q       <= dep_d;
            dir_q       <= dir_d;
            row_q       <= row_d;
            word_q      <= word_d;
            clr_cnt_q   <= clr_cnt_d;
            rd_vld_q    <= rd_en_i;
            if (rd_vld_q) begin
                rd_dat_q <= ram_rdat_i;
            end
        end
    end

endmodule

// File: tb/tb_db_tupu_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_db_tupu_wr_ctrl
// Directed bench for db_tupu_wr_ctrl with a behavioural 64x32 RAM.
// ---------------------------------------------------------------------------
module tb_db_tupu_wr_ctrl;

    logic        clk;
    logic        rst_n;
    logic        lcu_start_i;
    logic        cu_vld_i;
    logic        cu_rdy_o;
    logic [3:0]  cu_x_i;
    logic [3:0]  cu_y_i;
    logic [1:0]  cu_size_i;
    logic [1:0]  cu_part_i;
    logic [1:0]  cu_tu_dep_i;
    logic        rd_en_i;
    logic        rd_dir_i;
    logic [3:0]  rd_row_i;
    logic [31:0] rd_dat_o;
    logic        rd_vld_o;
    logic [5:0]  ram_adr_o;
    logic        ram_cen_o;
    logic        ram_wen_o;
    logic [31:0] ram_wdat_o;
    logic [31:0] ram_rdat_i;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [64];
    logic        mem_fill;
    logic [31:0] rb [32];
    int          rb_vld_bad;

    db_tupu_wr_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcu_start_i (lcu_start_i),
        .cu_vld_i    (cu_vld_i),
        .cu_rdy_o    (cu_rdy_o),
        .cu_x_i      (cu_x_i),
        .cu_y_i      (cu_y_i),
        .cu_size_i   (cu_size_i),
        .cu_part_i   (cu_part_i),
        .cu_tu_dep_i (cu_tu_dep_i),
        .rd_en_i     (rd_en_i),
        .rd_dir_i    (rd_dir_i),
        .rd_row_i    (rd_row_i),
        .rd_dat_o    (rd_dat_o),
        .rd_vld_o    (rd_vld_o),
        .ram_adr_o   (ram_adr_o),
        .ram_cen_o   (ram_cen_o),
        .ram_wen_o   (ram_wen_o),
        .ram_wdat_o  (ram_wdat_o),
        .ram_rdat_i  (ram_rdat_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM; starts filled with garbage so missing clears show up.
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'hA5A5_0000 | 32'(i);
            end
        end else if (!ram_cen_o) begin
            if (!ram_wen_o) begin
                mem[ram_adr_o] <= ram_wdat_o;
            end else begin
                ram_rdat_i <= mem[ram_adr_o];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int max_cyc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (cu_rdy_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: cu_rdy_o=%b after %0d cycles, required 1", name, cu_rdy_o, max_cyc);
        end
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy_o === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: busy_o=%b after %0d cycles, required 0", name, busy_o, max_cyc);
        end
    endtask

    task automatic do_start(input string name);
        tick();
        lcu_start_i = 1'b1;
        tick();
        lcu_start_i = 1'b0;
        wait_rdy(200, name);
    endtask

    // Hands over a descriptor from a negedge while cu_rdy_o is high.
    task automatic issue_cu(input logic [3:0] x, input logic [3:0] y, input logic [1:0] sz,
                            input logic [1:0] part, input logic [1:0] dep, input string name);
        wait_rdy(100, name);
        cu_x_i = x; cu_y_i = y; cu_size_i = sz; cu_part_i = part; cu_tu_dep_i = dep;
        cu_vld_i = 1'b1;
        tick();
        cu_vld_i = 1'b0;
    endtask

    task automatic send_cu(input logic [3:0] x, input logic [3:0] y, input logic [1:0] sz,
                           input logic [1:0] part, input logic [1:0] dep, input string name);
        issue_cu(x, y, sz, part, dep, name);
        wait_idle(300, name);
    endtask

    // Reads all 32 words of the read bank into rb[{dir,row}].
    task automatic read_bank();
        logic [4:0] a;
        rb_vld_bad = 0;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            tick();
            rd_en_i = 1'b1; rd_dir_i = a[4]; rd_row_i = a[3:0];
            tick();
            rd_en_i = 1'b0;
            @(negedge clk);
            if (rd_vld_o !== 1'b1) rb_vld_bad++;
            tick();
            @(negedge clk);
            if (rd_vld_o !== 1'b0) rb_vld_bad++;
            rb[i] = rd_dat_o;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lcu_start_i = 1'b0; cu_vld_i = 1'b0;
        cu_x_i = '0; cu_y_i = '0; cu_size_i = '0; cu_part_i = '0; cu_tu_dep_i = '0;
        rd_en_i = 1'b0; rd_dir_i = 1'b0; rd_row_i = '0;
        mem_fill = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_fill = 1'b0;
        @(negedge clk);
        checks++;
        if ({cu_rdy_o, rd_vld_o, busy_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: rdy/vld/busy=%b required 000", {cu_rdy_o, rd_vld_o, busy_o});
        end
        checks++;
        if (rd_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd_dat: got %h required 0", rd_dat_o);
        end
        checks++;
        if ({ram_cen_o, ram_wen_o, ram_adr_o, ram_wdat_o} !== {2'b11, 6'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_ram_port: cen=%b wen=%b adr=%h wdat=%h required 1 1 0 0",
                     ram_cen_o, ram_wen_o, ram_adr_o, ram_wdat_o);
        end
        tick();
        rst_n = 1'b1;
        // Before the first start nothing is accepted.
        cu_vld_i = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (cu_rdy_o !== 1'b0 || busy_o !== 1'b0) bad++;
                tick();
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rdy_before_start: %0d cycles with rdy/busy set, required 0", bad);
            end
        end
        cu_vld_i = 1'b0;
    endtask

    task automatic test_clear();
        int bad_wr = 0;
        int bad_flag = 0;
        tick();
        lcu_start_i = 1'b1;           // cycle 0
        tick();
        lcu_start_i = 1'b0;           // cycle 1
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (ram_cen_o !== 1'b0 || ram_wen_o !== 1'b0 || ram_wdat_o !== 32'h0 ||
                ram_adr_o !== {1'b1, 5'(i - 1)}) begin
                bad_wr++;
                $display("  clear cycle %0d: cen=%b wen=%b adr=%h wdat=%h", i, ram_cen_o,
                         ram_wen_o, ram_adr_o, ram_wdat_o);
            end
            if (cu_rdy_o !== 1'b0 || rd_vld_o !== 1'b0 || busy_o !== 1'b1) bad_flag++;
            tick();
        end
        checks++;
        if (bad_wr != 0) begin
            failures++;
            $display("FAIL clear_writes: %0d bad write cycles, required 0", bad_wr);
        end
        checks++;
        if (bad_flag != 0) begin
            failures++;
            $display("FAIL clear_flags: %0d cycles with bad rdy/vld/busy, required 0", bad_flag);
        end
        @(negedge clk);               // cycle 33
        checks++;
        if (cu_rdy_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_done_rdy: rdy=%b busy=%b at cycle 33, required 1 0", cu_rdy_o, busy_o);
        end
    endtask

    task automatic check_64(input string name);
        int bad = 0;
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            if (i < 16)       exp = 32'h0000_0003;
            else if (i == 16) exp = 32'hFFFF_FFFF;
            else              exp = 32'h0;
            if (rb[i] !== exp) begin
                bad++;
                $display("  %s word %0d: got %h expected %h", name, i, rb[i], exp);
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: %0d words differ, required 0", name, bad);
        end
        checks++;
        if (rb_vld_bad != 0) begin
            failures++;
            $display("FAIL %s_rd_vld: %0d bad rd_vld_o samples, required 0", name, rb_vld_bad);
        end
    endtask

    task automatic test_cu64();
        send_cu(4'd0, 4'd0, 2'd3, 2'd0, 2'd0, "cu64_send");
        do_start("cu64_start");
        read_bank();
        check_64("cu64_words");
    endtask

    task automatic check_8x8(input string name);
        int bad = 0;
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            exp = ((i % 16) == 4 || (i % 16) == 5) ? 32'h0000_00F0 : 32'h0;
            if (rb[i] !== exp) begin
                bad++;
                $display("  %s word %0d: got %h expected %h", name, i, rb[i], exp);
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: %0d words differ, required 0", name, bad);
        end
    endtask

    task automatic test_cu8();
        send_cu(4'd2, 4'd4, 2'd0, 2'd3, 2'd1, "cu8_send");
        do_start("cu8_start");
        read_bank();
        check_8x8("cu8_words");
    endtask

    task automatic test_back_to_back_merge();
        int bad = 0;
        logic [31:0] exp;
        send_cu(4'd0, 4'd0, 2'd1, 2'd0, 2'd0, "merge_send_a");
        send_cu(4'd4, 4'd0, 2'd1, 2'd0, 2'd0, "merge_send_b");
        do_start("merge_start");
        read_bank();
        for (int i = 0; i < 32; i++) begin
            if (i < 4)        exp = 32'h0000_0303;
            else if (i == 16) exp = 32'h0000_FFFF;
            else              exp = 32'h0;
            if (rb[i] !== exp) begin
                bad++;
                $display("  merge word %0d: got %h expected %h", i, rb[i], exp);
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL merge_words: %0d words differ, required 0", bad);
        end
    endtask

    task automatic test_contention();
        int stall_bad = 0;
        int vld_bad = 0;
        int busy_cyc = 0;
        logic [7:0] wv;
        wait_rdy(100, "cont_rdy");
        cu_x_i = 4'd0; cu_y_i = 4'd0; cu_size_i = 2'd3; cu_part_i = 2'd0; cu_tu_dep_i = 2'd0;
        cu_vld_i = 1'b1;
        tick();
        cu_vld_i = 1'b0;
        // Write bank is 0 here, so the reader addresses bank 1.
        for (int w = 0; w < 100; w++) begin
            wv = 8'(w);
            rd_en_i = 1'b1; rd_dir_i = wv[0]; rd_row_i = wv[4:1];
            @(negedge clk);
            if (ram_cen_o !== 1'b0 || ram_wen_o !== 1'b1 || busy_o !== 1'b1 ||
                ram_adr_o !== {1'b1, wv[0], wv[4:1]}) stall_bad++;
            if (w >= 1 && rd_vld_o !== 1'b1) vld_bad++;
            tick();
        end
        rd_en_i = 1'b0;
        @(negedge clk);
        if (rd_vld_o !== 1'b1) vld_bad++;
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL cont_stall: %0d cycles where the FSM reached the port, required 0", stall_bad);
        end
        checks++;
        if (vld_bad != 0) begin
            failures++;
            $display("FAIL cont_rd_vld: %0d cycles without rd_vld_o, required 0", vld_bad);
        end
        for (int i = 0; i < 300; i++) begin
            if (busy_o !== 1'b1) break;
            busy_cyc++;
            tick();
            @(negedge clk);
        end
        checks++;
        if (busy_cyc != 96) begin
            failures++;
            $display("FAIL cont_cu_cycles: busy for %0d cycles after release, required 96", busy_cyc);
        end
        do_start("cont_start");
        read_bank();
        check_64("cont_words");
    endtask

    task automatic test_pending_start();
        issue_cu(4'd2, 4'd4, 2'd0, 2'd3, 2'd1, "pend_send");
        tick(); tick();
        lcu_start_i = 1'b1;
        tick();
        lcu_start_i = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1 || cu_rdy_o !== 1'b0) begin
            failures++;
            $display("FAIL pend_busy: busy=%b rdy=%b, required 1 0", busy_o, cu_rdy_o);
        end
        tick();
        lcu_start_i = 1'b1;           // second pulse while pending, ignored
        tick();
        lcu_start_i = 1'b0;
        wait_rdy(200, "pend_rdy");
        // Only one clear should have run: the port stays quiet once ready.
        begin
            int bad = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (busy_o !== 1'b0 || cu_rdy_o !== 1'b1 || ram_cen_o !== 1'b1) bad++;
                tick();
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL pend_single_clear: %0d busy cycles after ready, required 0", bad);
            end
        end
        read_bank();
        check_8x8("pend_words");
        // Bank 0 held the contention CU; the deferred start must have cleared it.
        do_start("pend_restart");
        read_bank();
        begin
            int bad = 0;
            for (int i = 0; i < 32; i++) if (rb[i] !== 32'h0) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL pend_cleared_bank: %0d nonzero words, required 0", bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_cu64();
        test_cu8();
        test_back_to_back_merge();
        test_contention();
        test_pending_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
